// File: rtl/sram_512x4096_req_ctrl_pkg.sv
// sram_req_ctrl_pkg: shared types and defaults for the 512x4096 SRAM
// request controller.
//   state_e       controller FSM states (INIT, RUN)
//   *_DEF         default macro geometry
//   cnt_width()   width of the response credit counter for a given FIFO depth
package sram_req_ctrl_pkg;

  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int BITS_DEF       = 512;
  localparam int WORD_DEPTH_DEF = 4096;
  localparam int ADDR_WIDTH_DEF = 12;
  localparam int RSP_DEPTH_DEF  = 3;

  // cnt spans 0..RSP_DEPTH inclusive
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(RSP_DEPTH_DEF);

endpackage

// File: rtl/sram_512x4096_req_ctrl_if.sv
// sram_req_if: request/response bus between a client and the SRAM request
// controller.
//   req_valid/req_ready  request handshake
//   req_we/addr/wdata/wmask  request payload (wmask: 1 = write that bit)
//   rsp_valid/rsp_ready  read response handshake, rsp_rdata payload
// Modports: master = client side, slave = controller side.
interface sram_req_if
  import sram_req_ctrl_pkg::*;
#(
  parameter int BITS       = BITS_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [BITS-1:0]       req_wdata;
  logic [BITS-1:0]       req_wmask;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [BITS-1:0]       rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_wmask, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/sram_512x4096_req_ctrl_fifo.sv
// sram_req_rsp_fifo: small synchronous FIFO holding SRAM read responses.
//   clk, rst_n   clock, synchronous active-low reset (empties the FIFO)
//   push, wdata  write side; push while full is dropped (caller prevents it)
//   pop, rdata   read side; rdata is the head, pop while empty is ignored
//   full, empty  occupancy flags
module sram_req_rsp_fifo #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             do_push, do_pop;

  // depth need not be a power of two, so pointers wrap explicitly
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push != do_pop) count <= do_push ? count + 1'b1 : count - 1'b1;
    end
  end
endmodule

// File: rtl/sram_512x4096_req_ctrl.sv
// sram_512x4096_req_ctrl: request/response front-end for the 512x4096
// single-port SRAM macro. One SRAM access per accepted request; read data
// is captured the cycle after the read into a credit-guarded response FIFO.
//   clk, rst_n         clock, synchronous active-low reset
//   bus (slave)        req_* request stream in, rsp_* read responses out
//   sram_ce/we/addr/wd/wmask  macro pins; sram_rd macro read data
//   init_done          high once requests are accepted
// Optional macro SRAM_REQ_CTRL_INIT_EN: zero-fill sweep of the whole array
// during INIT (one word per cycle) before entering RUN.
module sram_512x4096_req_ctrl
  import sram_req_ctrl_pkg::*;
#(
  parameter int BITS       = BITS_DEF,
  parameter int WORD_DEPTH = WORD_DEPTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  sram_req_if.slave             bus,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [BITS-1:0]       sram_wd,
  output logic [BITS-1:0]       sram_wmask,
  input  logic [BITS-1:0]       sram_rd,
  output logic                  init_done
);
  localparam int       CW      = cnt_width(RSP_DEPTH);
  localparam logic [0:0] ST_INIT = INIT;
  localparam logic [0:0] ST_RUN  = RUN;

  logic [0:0]            state;
  logic                  run;
  logic [CW-1:0]         cnt;      // reads in flight + reads held in FIFO
  logic                  rd_pend;  // sram_rd is valid this cycle
  logic                  req_fire, rd_acc, rsp_pop;
  logic                  fifo_full, fifo_empty;
  logic                  init_wr;
  logic [ADDR_WIDTH-1:0] init_addr;

  assign run           = (state == ST_RUN);
  assign init_done     = run;
  assign bus.req_ready = run && (cnt < CW'(RSP_DEPTH));
  assign req_fire      = bus.req_valid & bus.req_ready;
  assign rd_acc        = req_fire & ~bus.req_we;
  assign rsp_pop       = bus.rsp_valid & bus.rsp_ready;

`ifdef SRAM_REQ_CTRL_INIT_EN
  // rst_n gates the sweep so the macro sees ce=0 while reset is held
  assign init_wr = (state == ST_INIT) & rst_n;

  // wraps back to 0 as the sweep finishes
  always_ff @(posedge clk)
    if (!rst_n)       init_addr <= '0;
    else if (init_wr) init_addr <= init_addr + 1'b1;

  always_ff @(posedge clk)
    if (!rst_n) state <= ST_INIT;
    else if (init_wr && (init_addr == ADDR_WIDTH'(WORD_DEPTH - 1))) state <= ST_RUN;
`else
  assign init_wr   = 1'b0;
  assign init_addr = '0;

  always_ff @(posedge clk)
    if (!rst_n) state <= ST_INIT;
    else        state <= ST_RUN;
`endif

  // Request fields pass straight through in RUN; outside RUN they are
  // parked (zero) unless the init sweep owns the macro.
  assign sram_ce    = req_fire | init_wr;
  assign sram_we    = init_wr | (run & bus.req_we);
  assign sram_addr  = init_wr ? init_addr : (run ? bus.req_addr : '0);
  assign sram_wd    = (run && !init_wr) ? bus.req_wdata : '0;
  assign sram_wmask = init_wr ? '1 : (run ? bus.req_wmask : '0);

  always_ff @(posedge clk)
    if (!rst_n) rd_pend <= 1'b0;
    else        rd_pend <= rd_acc;

  always_ff @(posedge clk)
    if (!rst_n)                cnt <= '0;
    else if (rd_acc != rsp_pop) cnt <= rd_acc ? cnt + 1'b1 : cnt - 1'b1;

  sram_req_rsp_fifo #(
    .WIDTH (BITS),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (rd_pend),
    .wdata (sram_rd),
    .pop   (rsp_pop),
    .rdata (bus.rsp_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.rsp_valid = ~fifo_empty;

  // credits guarantee a free slot for every captured read
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(rd_pend && fifo_full));

  a_addr_range: assert property (@(posedge clk) disable iff (!rst_n)
    !req_fire || (32'(bus.req_addr) < WORD_DEPTH));
endmodule

// File: tb/tb_sram_512x4096_req_ctrl.sv
module tb_sram_512x4096_req_ctrl;
  localparam int BITS = 512;
  localparam int AW   = 12;
`ifdef SRAM_REQ_CTRL_INIT_EN
  localparam int EXP_INIT = 4096;
`else
  localparam int EXP_INIT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            sram_ce, sram_we, init_done;
  logic [AW-1:0]   sram_addr;
  logic [BITS-1:0] sram_wd, sram_wmask, sram_rd;

  sram_req_if #(.BITS(BITS), .ADDR_WIDTH(AW)) bus ();

  sram_512x4096_req_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .sram_ce    (sram_ce),
    .sram_we    (sram_we),
    .sram_addr  (sram_addr),
    .sram_wd    (sram_wd),
    .sram_wmask (sram_wmask),
    .sram_rd    (sram_rd),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  // macro model: read data valid only the cycle after a read, junk otherwise
  logic [BITS-1:0] mem [4096];
  logic [BITS-1:0] rd_q;
  always @(posedge clk) begin
    if (sram_ce && sram_we)
      mem[sram_addr] <= (mem[sram_addr] & ~sram_wmask) | (sram_wd & sram_wmask);
    if (sram_ce && !sram_we) rd_q <= mem[sram_addr];
    else                     rd_q <= {16{$urandom}};
  end
  assign sram_rd = rd_q;

  int errors = 0;
  int checks = 0;

  task automatic chk1(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [BITS-1:0] act, input logic [BITS-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [BITS-1:0] pat(input int i);
    return {16{32'hC0DE0000 + 32'(i)}};
  endfunction

  typedef struct {
    logic            we;
    logic [AW-1:0]   addr;
    logic [BITS-1:0] wd;
    logic [BITS-1:0] wm;
    logic [BITS-1:0] exp;
    string           nm;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [AW-1:0] a, input logic [BITS-1:0] wd,
                              input logic [BITS-1:0] wm, input logic [BITS-1:0] exp, input string nm);
    vec_t v;
    v.we = we; v.addr = a; v.wd = wd; v.wm = wm; v.exp = exp; v.nm = nm;
    return v;
  endfunction

  // entered and left at posedge+1
  task automatic do_op(input vec_t v);
    int w;
    bus.req_valid = 1'b1; bus.req_we = v.we; bus.req_addr = v.addr;
    bus.req_wdata = v.wd; bus.req_wmask = v.wm; bus.rsp_ready = 1'b1;
    w = 0;
    @(negedge clk);
    while (!bus.req_ready && w < 20) begin w++; @(negedge clk); end
    chk1({v.nm, "_ready"}, 32'(bus.req_ready), 1);
    chk1({v.nm, "_ce"}, 32'(sram_ce), 1);
    chk1({v.nm, "_we"}, 32'(sram_we), 32'(v.we));
    chk1({v.nm, "_addr"}, 32'(sram_addr), 32'(v.addr));
    if (v.we) chkw({v.nm, "_wmask"}, sram_wmask, v.wm);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk1({v.nm, "_ce_drop"}, 32'(sram_ce), 0);
    chk1({v.nm, "_no_early_rsp"}, 32'(bus.rsp_valid), 0);
    if (!v.we) begin
      @(negedge clk);
      chk1({v.nm, "_rsp_valid"}, 32'(bus.rsp_valid), 1);
      chkw({v.nm, "_rdata"}, bus.rsp_rdata, v.exp);
    end
    @(posedge clk); #1;
  endtask

  // starts at posedge+1 just after rst_n rises
  task automatic wait_init();
    int n;
    n = 0;
    @(negedge clk);
    chk1("init_first_ready", 32'(bus.req_ready), 0);
`ifdef SRAM_REQ_CTRL_INIT_EN
    chk1("sweep_start_addr", 32'(sram_addr), 0);
    chk1("sweep_ce", 32'(sram_ce), 1);
    chk1("sweep_we", 32'(sram_we), 1);
    chkw("sweep_wmask", sram_wmask, '1);
    chkw("sweep_wd", sram_wd, '0);
`endif
    while (!init_done && n < 10000) begin
      n++;
      @(negedge clk);
      if (!init_done) chk1("init_ready_low", 32'(bus.req_ready), 0);
    end
    chk1("init_cycles", 32'(n), 32'(EXP_INIT));
    chk1("ready_after_init", 32'(bus.req_ready), 1);
    @(posedge clk); #1;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  vec_t vt[7];
  int   acc, bad, got, cyc, first, last, k;
  logic [BITS-1:0] a5, all1, lo_mask;

  initial begin
    a5 = {64{8'hA5}};
    all1 = '1;
    lo_mask = {{256{1'b0}}, {256{1'b1}}};
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_wdata = '0; bus.req_wmask = '0; bus.rsp_ready = 1'b0;

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_req_ready", 32'(bus.req_ready), 0);
    chk1("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk1("rst_sram_ce", 32'(sram_ce), 0);
    chk1("rst_sram_we", 32'(sram_we), 0);
    chk1("rst_sram_addr", 32'(sram_addr), 0);
    chk1("rst_init_done", 32'(init_done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init();

    // directed single-transaction table
    vt[0] = mk(1'b1, 12'h123, a5, all1, '0, "wr_a5");
    vt[1] = mk(1'b0, 12'h123, '0, '0, a5, "rd_a5");
    vt[2] = mk(1'b1, 12'h010, all1, all1, '0, "wr_ones");
    vt[3] = mk(1'b1, 12'h010, '0, lo_mask, '0, "wr_masked");
    vt[4] = mk(1'b0, 12'h010, '0, '0, {{256{1'b1}}, {256{1'b0}}}, "rd_masked");
    vt[5] = mk(1'b1, 12'hFFE, {64{8'h5A}}, all1, '0, "wr_5a");
    vt[6] = mk(1'b0, 12'hFFE, '0, '0, {64{8'h5A}}, "rd_5a");
    for (int i = 0; i < 7; i++) do_op(vt[i]);

    // read then write same address back-to-back: read sees old data
    bus.rsp_ready = 1'b1;
    bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h123;
    @(posedge clk); #1;
    bus.req_we = 1'b1; bus.req_wdata = {64{8'h3C}}; bus.req_wmask = all1;
    @(negedge clk);
    chk1("raw_wr_ce", 32'(sram_ce & sram_we), 1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk1("raw_rsp_valid", 32'(bus.rsp_valid), 1);
    chkw("raw_old_data", bus.rsp_rdata, a5);
    @(posedge clk); #1;
    do_op(mk(1'b0, 12'h123, '0, '0, {64{8'h3C}}, "raw_new_data"));

    // streaming: 100 writes then 100 reads, back-to-back
    bad = 0;
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_wmask = all1;
    for (int i = 0; i < 100; i++) begin
      bus.req_addr = 12'h300 + 12'(i); bus.req_wdata = pat(i);
      @(negedge clk);
      if (!bus.req_ready) bad++;
      @(posedge clk); #1;
    end
    bus.req_valid = 1'b0;
    chk1("stream_wr_ready_drops", 32'(bad), 0);
    got = 0; cyc = 0; first = -1; last = -1;
    bus.rsp_ready = 1'b1;
    fork
      begin
        bus.req_valid = 1'b1; bus.req_we = 1'b0;
        for (int i = 0; i < 100; i++) begin
          bus.req_addr = 12'h300 + 12'(i);
          @(negedge clk);
          if (!bus.req_ready) bad++;
          @(posedge clk); #1;
        end
        bus.req_valid = 1'b0;
      end
      begin
        while (got < 100 && cyc < 400) begin
          @(negedge clk);
          cyc++;
          if (bus.rsp_valid) begin
            chkw("stream_rdata", bus.rsp_rdata, pat(got));
            if (first < 0) first = cyc;
            last = cyc;
            got++;
          end
        end
      end
    join
    chk1("stream_rd_ready_drops", 32'(bad), 0);
    chk1("stream_rsp_count", 32'(got), 100);
    chk1("stream_one_per_cycle", 32'(last - first), 99);
    chk1("stream_first_latency", 32'(first), 3);
    @(posedge clk); #1;

    // backpressure: three credits then stall
    acc = 0;
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h300;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.req_ready) acc++;
      @(posedge clk); #1;
      bus.req_addr = 12'h300 + 12'(acc);
    end
    bus.req_valid = 1'b0;
    @(negedge clk);
    chk1("bp_accepted", 32'(acc), 3);
    chk1("bp_ready_low", 32'(bus.req_ready), 0);
    chk1("bp_rsp_valid", 32'(bus.rsp_valid), 1);
    chkw("bp_head_held", bus.rsp_rdata, pat(0));
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    for (k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1("bp_drain_valid", 32'(bus.rsp_valid), 1);
      chkw("bp_drain_data", bus.rsp_rdata, pat(k));
      chk1("bp_ready_after_pop", 32'(bus.req_ready), (k == 0) ? 0 : 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk1("bp_drained", 32'(bus.rsp_valid), 0);
    @(posedge clk); #1;

    // reset with two reads in flight
    bus.rsp_ready = 1'b0; bus.req_valid = 1'b1; bus.req_we = 1'b0; bus.req_addr = 12'h300;
    @(posedge clk); #1;
    bus.req_addr = 12'h301;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk1("mid_rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk1("mid_rst_cnt", 32'(dut.cnt), 0);
    chk1("mid_rst_ce_gated", 32'(sram_ce), 0);
    chk1("mid_rst_init_done", 32'(init_done), 0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0; bus.rsp_ready = 1'b1;
    rst_n = 1'b1;
    wait_init();
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) bad++;
    end
    chk1("mid_rst_no_stale_rsp", 32'(bad), 0);
    @(posedge clk); #1;

`ifdef SRAM_REQ_CTRL_INIT_EN
    do_op(mk(1'b1, 12'hFFF, all1, all1, '0, "wr_fff_ones"));
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    k = 0;
    @(negedge clk);
    while (sram_addr != 12'h800 && k < 5000) begin k++; @(negedge clk); end
    chk1("sweep_reaches_800", 32'(k), 2048);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_init();
    do_op(mk(1'b0, 12'hFFF, '0, '0, '0, "rd_fff_zero"));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
